// File: rtl/frame_buffer_pingpong_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | frame_buffer_pingpong_if                                                 |
// | Bus bundle for the ping-pong frame buffer: port A, port B, swap, clear.  |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
interface frame_buffer_pingpong_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   a_addr;
    logic [DATA_W-1:0]   a_wdata;
    logic [DATA_W/8-1:0] a_be;
    logic                a_we;
    logic                a_re;
    logic [DATA_W-1:0]   a_rdata;
    logic                a_rvalid;
    logic                a_ready;
    logic [ADDR_W-1:0]   b_addr;
    logic                b_re;
    logic [DATA_W-1:0]   b_rdata;
    logic                b_rvalid;
    logic                frame_start;
    logic                swap_req;
    logic                swap_pending;
    logic                swap_done;
    logic                front_bank;
    logic                clear_start;
    logic [DATA_W-1:0]   clear_value;
    logic                clear_busy;
    logic                addr_err;

    modport master (
        output a_addr, a_wdata, a_be, a_we, a_re, b_addr, b_re,
               frame_start, swap_req, clear_start, clear_value,
        input  a_rdata, a_rvalid, a_ready, b_rdata, b_rvalid,
               swap_pending, swap_done, front_bank, clear_busy, addr_err
    );

    modport slave (
        input  a_addr, a_wdata, a_be, a_we, a_re, b_addr, b_re,
               frame_start, swap_req, clear_start, clear_value,
        output a_rdata, a_rvalid, a_ready, b_rdata, b_rvalid,
               swap_pending, swap_done, front_bank, clear_busy, addr_err
    );
endinterface
`default_nettype wire

// File: rtl/frame_buffer_pingpong.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | frame_buffer_pingpong                                                    |
// | Double-buffered frame memory with frame-aligned bank swap and clear      |
// | engine. Optional macro FB_BYTE_ENABLE_EN enables port A byte lanes.      |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module frame_buffer_pingpong #(
    parameter int WIDTH        = 96,
    parameter int HEIGHT       = 48,
    parameter int CHAINED      = 1,
    parameter int DATA_W       = 32,
    parameter int PIX_PER_WORD = 2,
    parameter int DEPTH        = CHAINED * WIDTH * HEIGHT / PIX_PER_WORD,
    parameter int ADDR_W       = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    frame_buffer_pingpong_if.slave bus
);
    localparam logic [ADDR_W:0]   c_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] c_LAST  = ADDR_W'(DEPTH - 1);

    localparam logic [0:0] c_SWAP_IDLE = 1'b0;
    localparam logic [0:0] c_SWAP_PEND = 1'b1;
    localparam logic [0:0] c_CLR_IDLE  = 1'b0;
    localparam logic [0:0] c_CLR_RUN   = 1'b1;

    logic [DATA_W-1:0] mem_q [2][DEPTH];

    logic              front_q, front_d;
    logic [0:0]        swap_st_q, swap_st_d;
    logic              swap_done_q, swap_done_d;
    logic [0:0]        clr_st_q, clr_st_d;
    logic              clr_bank_q, clr_bank_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [DATA_W-1:0] clr_val_q, clr_val_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
    logic              a_rvalid_q, a_rvalid_d;
    logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
    logic              b_rvalid_q, b_rvalid_d;
    logic              err_q, err_d;

    logic              w_busy, w_back, w_a_wr, w_a_rd, w_a_oor, w_b_oor;
    logic              w_want, w_take;
    logic              w_wr_en, w_wr_bank;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [DATA_W-1:0] w_wr_data, w_wr_mask;

`ifndef FB_BYTE_ENABLE_EN
    logic w_unused_be;
    assign w_unused_be = ^bus.a_be;
`endif

    assign w_busy  = (clr_st_q == c_CLR_RUN);
    assign w_back  = ~front_q;
    assign w_a_wr  = ~w_busy & bus.a_we;
    assign w_a_rd  = ~w_busy & bus.a_re & ~bus.a_we;
    assign w_a_oor = ({1'b0, bus.a_addr} >= c_DEPTH);
    assign w_b_oor = ({1'b0, bus.b_addr} >= c_DEPTH);
    assign w_want  = (swap_st_q == c_SWAP_PEND) | bus.swap_req;
    assign w_take  = w_want & bus.frame_start & ~w_busy;

    // Single write port: the clear engine owns it while running, else port A.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_bank = w_back;
        w_wr_addr = bus.a_addr;
        w_wr_data = bus.a_wdata;
        w_wr_mask = '1;
        if (w_busy) begin
            w_wr_en   = 1'b1;
            w_wr_bank = clr_bank_q;
            w_wr_addr = clr_cnt_q;
            w_wr_data = clr_val_q;
        end else if (w_a_wr && !w_a_oor) begin
            w_wr_en = 1'b1;
`ifdef FB_BYTE_ENABLE_EN
            for (int i = 0; i < DATA_W/8; i++) begin
                w_wr_mask[8*i +: 8] = {8{bus.a_be[i]}};
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_wr_en) begin
            mem_q[w_wr_bank][w_wr_addr] <= (mem_q[w_wr_bank][w_wr_addr] & ~w_wr_mask)
                                         | (w_wr_data & w_wr_mask);
        end
    end

    always_comb begin
        front_d     = front_q ^ w_take;
        swap_done_d = w_take;
        swap_st_d   = (w_want && !w_take) ? c_SWAP_PEND : c_SWAP_IDLE;

        clr_st_d    = clr_st_q;
        clr_bank_d  = clr_bank_q;
        clr_cnt_d   = clr_cnt_q;
        clr_val_d   = clr_val_q;
        if (w_busy) begin
            clr_cnt_d = clr_cnt_q + ADDR_W'(1);
            if (clr_cnt_q == c_LAST) clr_st_d = c_CLR_IDLE;
        end else if (bus.clear_start) begin
            clr_st_d   = c_CLR_RUN;
            clr_bank_d = w_back;
            clr_cnt_d  = '0;
            clr_val_d  = bus.clear_value;
        end

        a_rvalid_d = w_a_rd;
        a_rdata_d  = a_rdata_q;
        if (w_a_rd) a_rdata_d = w_a_oor ? '0 : mem_q[w_back][bus.a_addr];
        b_rvalid_d = bus.b_re;
        b_rdata_d  = b_rdata_q;
        if (bus.b_re) b_rdata_d = w_b_oor ? '0 : mem_q[front_q][bus.b_addr];

        err_d = err_q | ((w_a_wr | w_a_rd) & w_a_oor) | (bus.b_re & w_b_oor);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            front_q     <= 1'b0;
            swap_st_q   <= c_SWAP_IDLE;
            swap_done_q <= 1'b0;
            clr_st_q    <= c_CLR_IDLE;
            clr_bank_q  <= 1'b0;
            clr_cnt_q   <= '0;
            clr_val_q   <= '0;
            a_rdata_q   <= '0;
            a_rvalid_q  <= 1'b0;
            b_rdata_q   <= '0;
            b_rvalid_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            front_q     <= front_d;
            swap_st_q   <= swap_st_d;
            swap_done_q <= swap_done_d;
            clr_st_q    <= clr_st_d;
            clr_bank_q  <= clr_bank_d;
            clr_cnt_q   <= clr_cnt_d;
            clr_val_q   <= clr_val_d;
            a_rdata_q   <= a_rdata_d;
            a_rvalid_q  <= a_rvalid_d;
            b_rdata_q   <= b_rdata_d;
            b_rvalid_q  <= b_rvalid_d;
            err_q       <= err_d;
        end
    end

    assign bus.a_rdata      = a_rdata_q;
    assign bus.a_rvalid     = a_rvalid_q;
    assign bus.a_ready      = ~w_busy;
    assign bus.b_rdata      = b_rdata_q;
    assign bus.b_rvalid     = b_rvalid_q;
    assign bus.swap_pending = (swap_st_q == c_SWAP_PEND);
    assign bus.swap_done    = swap_done_q;
    assign bus.front_bank   = front_q;
    assign bus.clear_busy   = w_busy;
    assign bus.addr_err     = err_q;
endmodule
`default_nettype wire

// File: tb/tb_frame_buffer_pingpong.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_frame_buffer_pingpong                                                 |
// | Self-checking bench: vector table, corner sequences, random vs model.    |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_frame_buffer_pingpong;
    localparam int DEPTH  = 2304;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;

`ifdef FB_BYTE_ENABLE_EN
    localparam logic [31:0] c_E_BE  = 32'h11BB33DD;
    localparam logic [31:0] c_E_BE0 = 32'h01010101;
`else
    localparam logic [31:0] c_E_BE  = 32'hAABBCCDD;
    localparam logic [31:0] c_E_BE0 = 32'h00000077;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    frame_buffer_pingpong_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
    frame_buffer_pingpong dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m [2][DEPTH];
    bit          mf, mpend, mdone, mbusy, marv, mbrv, merr, mcbank;
    int          mcnt;
    logic [31:0] mcval, mard, mbrd;

    typedef struct {
        bit          we, re;
        logic [3:0]  be;
        logic [11:0] addr;
        logic [31:0] wd;
        bit          bre;
        logic [11:0] baddr;
        bit          e_arv;
        logic [31:0] e_ard;
        bit          e_brv;
        logic [31:0] e_brd;
        bit          e_err;
    } vec_t;
    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_step();
        bit want, take, back;
        int a, b;
        a = int'(bus.a_addr);
        b = int'(bus.b_addr);
        back = !mf;
        marv = 0; mbrv = 0;
        if (rst) begin
            mf = 0; mpend = 0; mdone = 0; mbusy = 0; merr = 0; mard = 0; mbrd = 0;
            return;
        end
        want = mpend || bus.swap_req;
        take = want && bus.frame_start && !mbusy;
        if (!mbusy && bus.a_re && !bus.a_we) begin
            marv = 1;
            mard = (a < DEPTH) ? m[back][a] : 32'h0;
            if (a >= DEPTH) merr = 1;
        end
        if (bus.b_re) begin
            mbrv = 1;
            mbrd = (b < DEPTH) ? m[mf][b] : 32'h0;
            if (b >= DEPTH) merr = 1;
        end
        if (!mbusy && bus.a_we) begin
            if (a >= DEPTH) merr = 1;
            else begin
`ifdef FB_BYTE_ENABLE_EN
                for (int i = 0; i < 4; i++)
                    if (bus.a_be[i]) m[back][a][8*i +: 8] = bus.a_wdata[8*i +: 8];
`else
                m[back][a] = bus.a_wdata;
`endif
            end
        end
        if (mbusy) begin
            m[mcbank][mcnt] = mcval;
            mcnt++;
            if (mcnt == DEPTH) mbusy = 0;
        end else if (bus.clear_start) begin
            mbusy = 1; mcnt = 0; mcbank = back; mcval = bus.clear_value;
        end
        if (take) mf = !mf;
        mpend = want && !take;
        mdone = take;
    endtask

    task automatic check_all();
        chk("a_rdata",      bus.a_rdata,      mard);
        chk("a_rvalid",     32'(bus.a_rvalid),     32'(marv));
        chk("b_rdata",      bus.b_rdata,      mbrd);
        chk("b_rvalid",     32'(bus.b_rvalid),     32'(mbrv));
        chk("front_bank",   32'(bus.front_bank),   32'(mf));
        chk("swap_pending", 32'(bus.swap_pending), 32'(mpend));
        chk("swap_done",    32'(bus.swap_done),    32'(mdone));
        chk("clear_busy",   32'(bus.clear_busy),   32'(mbusy));
        chk("a_ready",      32'(bus.a_ready),      32'(!mbusy));
        chk("addr_err",     32'(bus.addr_err),     32'(merr));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic idle();
        bus.a_we = 0; bus.a_re = 0; bus.b_re = 0;
        bus.swap_req = 0; bus.frame_start = 0; bus.clear_start = 0;
    endtask

    task automatic wait_clear(output int nb);
        int guard = 0;
        nb = 0;
        while (bus.clear_busy && guard < 3000) begin
            tick();
            if (bus.clear_busy) nb++;
            guard++;
        end
        if (guard >= 3000) chk("clear_timeout", 32'(guard), 32'(DEPTH));
    endtask

    task automatic do_clear(input logic [31:0] v);
        int nb;
        bus.clear_start = 1; bus.clear_value = v;
        tick();
        bus.clear_start = 0;
        wait_clear(nb);
    endtask

    task automatic do_swap();
        bus.swap_req = 1; bus.frame_start = 1;
        tick();
        bus.swap_req = 0; bus.frame_start = 0;
    endtask

    initial begin
        int nb;
        tbl[0]  = '{1, 0, 4'hF, 12'd5,    32'hDEADBEEF, 0, 12'd0, 0, 32'h0,        0, 32'h0,        0};
        tbl[1]  = '{0, 1, 4'hF, 12'd5,    32'h0,        0, 12'd0, 1, 32'hDEADBEEF, 0, 32'h0,        0};
        tbl[2]  = '{0, 0, 4'hF, 12'd0,    32'h0,        1, 12'd5, 0, 32'hDEADBEEF, 1, 32'h02020202, 0};
        tbl[3]  = '{1, 0, 4'hF, 12'd7,    32'h11223344, 0, 12'd0, 0, 32'hDEADBEEF, 0, 32'h02020202, 0};
        tbl[4]  = '{1, 0, 4'h5, 12'd7,    32'hAABBCCDD, 0, 12'd0, 0, 32'hDEADBEEF, 0, 32'h02020202, 0};
        tbl[5]  = '{0, 1, 4'hF, 12'd7,    32'h0,        0, 12'd0, 1, c_E_BE,       0, 32'h02020202, 0};
        tbl[6]  = '{1, 1, 4'hF, 12'd9,    32'h00000055, 0, 12'd0, 0, c_E_BE,       0, 32'h02020202, 0};
        tbl[7]  = '{0, 1, 4'hF, 12'd9,    32'h0,        0, 12'd0, 1, 32'h00000055, 0, 32'h02020202, 0};
        tbl[8]  = '{1, 0, 4'h0, 12'd3,    32'h00000077, 0, 12'd0, 0, 32'h00000055, 0, 32'h02020202, 0};
        tbl[9]  = '{0, 1, 4'hF, 12'd3,    32'h0,        0, 12'd0, 1, c_E_BE0,      0, 32'h02020202, 0};
        tbl[10] = '{0, 1, 4'hF, 12'd2400, 32'h0,        0, 12'd0, 1, 32'h0,        0, 32'h02020202, 1};
        tbl[11] = '{0, 0, 4'hF, 12'd0,    32'h0,        0, 12'd0, 0, 32'h0,        0, 32'h02020202, 1};

        idle();
        bus.a_addr = 0; bus.a_wdata = 0; bus.a_be = 4'hF; bus.b_addr = 0; bus.clear_value = 0;
        rst = 1;
        repeat (3) tick();
        rst = 0;
        chk("rst_front", 32'(bus.front_bank), 32'h0);
        chk("rst_ready", 32'(bus.a_ready), 32'h1);

        // Known contents: bank1 = 0x01010101, bank0 = 0x02020202, front back to 0
        do_clear(32'h01010101);
        do_swap();
        do_clear(32'h02020202);
        do_swap();

        for (int i = 0; i < 12; i++) begin
            bus.a_we = tbl[i].we; bus.a_re = tbl[i].re; bus.a_be = tbl[i].be;
            bus.a_addr = tbl[i].addr; bus.a_wdata = tbl[i].wd;
            bus.b_re = tbl[i].bre; bus.b_addr = tbl[i].baddr;
            tick();
            chk($sformatf("vec%0d_arvalid", i), 32'(bus.a_rvalid), 32'(tbl[i].e_arv));
            chk($sformatf("vec%0d_ardata", i),  bus.a_rdata,       tbl[i].e_ard);
            chk($sformatf("vec%0d_brvalid", i), 32'(bus.b_rvalid), 32'(tbl[i].e_brv));
            chk($sformatf("vec%0d_brdata", i),  bus.b_rdata,       tbl[i].e_brd);
            chk($sformatf("vec%0d_err", i),     32'(bus.addr_err), 32'(tbl[i].e_err));
        end
        idle();
        bus.a_be = 4'hF;

        // Delayed swap
        bus.swap_req = 1; tick(); bus.swap_req = 0;
        repeat (10) tick();
        chk("seq1_pending", 32'(bus.swap_pending), 32'h1);
        bus.frame_start = 1; tick(); bus.frame_start = 0;
        chk("seq1_front", 32'(bus.front_bank), 32'h1);
        chk("seq1_done", 32'(bus.swap_done), 32'h1);
        tick();
        chk("seq1_done_low", 32'(bus.swap_done), 32'h0);
        bus.b_re = 1; bus.b_addr = 5; tick(); bus.b_re = 0;
        chk("seq1_bread", bus.b_rdata, 32'hDEADBEEF);

        // Immediate swap; B read in the same cycle sees the old front
        bus.swap_req = 1; bus.frame_start = 1; bus.b_re = 1; bus.b_addr = 5;
        tick();
        idle();
        chk("seq2_bread_old", bus.b_rdata, 32'hDEADBEEF);
        chk("seq2_front", 32'(bus.front_bank), 32'h0);
        chk("seq2_done", 32'(bus.swap_done), 32'h1);
        bus.b_re = 1; tick(); bus.b_re = 0;
        chk("seq2_bread_new", bus.b_rdata, 32'h02020202);

        // Clear with dropped write and a swap held off by the clear
        bus.clear_start = 1; bus.clear_value = 32'h00000FFF; tick(); bus.clear_start = 0;
        chk("seq3_busy", 32'(bus.clear_busy), 32'h1);
        chk("seq3_ready", 32'(bus.a_ready), 32'h0);
        nb = 1;
        bus.a_we = 1; bus.a_addr = 10; bus.a_wdata = 32'h12345678; tick(); bus.a_we = 0;
        if (bus.clear_busy) nb++;
        bus.a_re = 1; tick(); bus.a_re = 0;
        if (bus.clear_busy) nb++;
        chk("seq3_no_rvalid", 32'(bus.a_rvalid), 32'h0);
        bus.swap_req = 1; tick(); bus.swap_req = 0;
        if (bus.clear_busy) nb++;
        bus.frame_start = 1; tick(); bus.frame_start = 0;
        if (bus.clear_busy) nb++;
        chk("seq3_no_swap", 32'(bus.front_bank), 32'h0);
        chk("seq3_still_pend", 32'(bus.swap_pending), 32'h1);
        begin
            int rest;
            wait_clear(rest);
            nb += rest;
        end
        chk("seq3_busy_cycles", 32'(nb), 32'(DEPTH));
        bus.a_re = 1; bus.a_addr = 0; tick();
        chk("seq3_rd0", bus.a_rdata, 32'h00000FFF);
        bus.a_addr = 2303; tick();
        chk("seq3_rd2303", bus.a_rdata, 32'h00000FFF);
        bus.a_addr = 10; tick(); bus.a_re = 0;
        chk("seq3_rd10", bus.a_rdata, 32'h00000FFF);
        bus.frame_start = 1; tick(); bus.frame_start = 0;
        chk("seq3_swap_after", 32'(bus.front_bank), 32'h1);
        chk("seq3_done", 32'(bus.swap_done), 32'h1);

        // Random traffic against the model
        for (int n = 0; n < 4000; n++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            bus.a_we    = ($urandom_range(0, 2) == 0);
            bus.a_re    = ($urandom_range(0, 2) == 0);
            bus.a_be    = 4'($urandom);
            bus.a_wdata = $urandom;
            bus.a_addr  = (sel < 7) ? 12'($urandom_range(0, 15))
                        : (sel < 9) ? 12'($urandom_range(2290, 2303))
                        :             12'($urandom_range(2304, 4095));
            bus.b_re    = ($urandom_range(0, 1) == 0);
            bus.b_addr  = (sel == 3) ? 12'($urandom_range(2300, 2310)) : 12'($urandom_range(0, 15));
            bus.swap_req    = ($urandom_range(0, 19) == 0);
            bus.frame_start = ($urandom_range(0, 14) == 0);
            bus.clear_start = ($urandom_range(0, 999) == 0);
            bus.clear_value = $urandom;
            if (bus.clear_start) begin
                bus.swap_req = 0; bus.frame_start = 0;
            end
            tick();
        end
        idle();

        // Reset clears sticky error and mapping
        chk("pre_rst_err", 32'(bus.addr_err), 32'h1);
        rst = 1; tick(); rst = 0;
        chk("post_rst_err", 32'(bus.addr_err), 32'h0);
        chk("post_rst_front", 32'(bus.front_bank), 32'h0);
        chk("post_rst_busy", 32'(bus.clear_busy), 32'h0);
        chk("post_rst_rvalid", 32'(bus.a_rvalid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
